dequantize: RTL and testbench
=============================

# dequantize

Streaming int8-to-int32 expansion stage: takes SIZE packed signed 8-bit pixels, removes a fixed zero-point, and left-shifts each lane back into the 32-bit fixed-point accumulator domain. It sits at the input of a layer (or between layers) and feeds 32-bit datapaths that expect requantize-compatible scaling. It is a two-stage registered pipeline with valid/ready handshakes on both sides, full throughput, and backpressure.

## Interface
- SHIFT, 0: left shift applied after zero-point removal; legal range 0..23.
- SIZE, 1: number of parallel lanes.
- ZERO_POINT, 0: signed 8-bit zero-point subtracted from every lane; legal range -128..127.

- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pixel_in  input  8*SIZE  lane i at [8*i+7:8*i], signed two's complement.
- in_valid  input  1  pixel_in holds a beat.
- in_ready  output  1  block accepts a beat this cycle.
- pixel_out  output  32*SIZE  lane i at [32*i+31:32*i], signed two's complement.
- out_valid  output  1  pixel_out holds a beat.
- out_ready  input  1  downstream accepts pixel_out this cycle.

## Operation
- Per lane, stage 1: d = sext9(pixel_in lane) - sext9(ZERO_POINT); 9-bit signed, range -255..255, never overflows.
- Per lane, stage 2: q = sext32(d) << SHIFT; with SHIFT<=23 the result fits 32 bits, no saturation logic.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage registers: s1 (d values + s1_valid), s2 (pixel_out + out_valid).
- s2 loads from s1 when s1_valid && (!out_valid || out_ready); otherwise out_valid clears on output transfer.
- s1 loads from input on input transfer; s1_valid clears when s1 moves to s2 without a new input.
- in_ready = !reset && (!s1_valid || s1 moves to s2 this cycle). Combinational from out_ready; no combinational path from in_valid to in_ready.
- pixel_out and s1 data hold their values while stalled; data registers not updated by any non-transfer cycle.
- All lanes share one valid/ready pair; lanes are processed identically and independently.

## Timing
- Reset (synchronous, one or more cycles): s1_valid=0, out_valid=0, pixel_out=0, s1 data=0; in_ready=0 while reset high, 1 on the first cycle after.
- Reset mid-operation discards every in-flight beat; no beat accepted during a reset cycle.
- Latency: beat accepted in cycle N appears with out_valid=1 in cycle N+2 when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Capacity: 2 beats. With out_ready low, block accepts exactly two beats, then in_ready=0.
- out_ready rising while full: output transfer, s1->s2 and new input acceptance all occur in the same cycle.
- Simultaneous in_valid/out_ready toggling must never drop, duplicate or reorder beats.
- out_valid and pixel_out are stable until transfer once out_valid is asserted.

## Configuration
- DEQUANTIZE_ROUND_EN defined: stage 2 adds midpoint offset, q = (sext32(d) << SHIFT) + (1 << (SHIFT-1)) when SHIFT>0; SHIFT=0 unaffected. Reconstructs the centre of the truncation bin of a floor-style requantizer. Max result (255<<23)+(1<<22) still fits 32 bits.
- Not defined: q = sext32(d) << SHIFT exactly; no adder in stage 2.
- Latency, handshake and reset behaviour identical in both builds.

## Test plan
- Reset then single beat, SIZE=2, SHIFT=4, ZERO_POINT=0, lanes {8'h7F, 8'h80}, out_ready=1 -> two cycles later out_valid=1, lanes {32'h000007F0, 32'hFFFFF800}; out_valid=0 next cycle.
- ZERO_POINT=-128, SHIFT=0, lane 8'h7F -> 32'd255; lane 8'h80 -> 32'd0; ZERO_POINT=127, lane 8'h80 -> 32'hFFFFFF01 (-255).
- Backpressure: out_ready=0, in_valid=1 with beats 1,2,3 -> beats 1,2 accepted, in_ready=0 thereafter; release out_ready -> outputs 1,2,3 in order, no gaps after release, none lost or duplicated.
- Streaming: 100 random beats, random in_valid and out_ready (50%) -> output sequence equals reference model of accepted beats; full-throughput run of 16 beats with both held high takes 18 cycles.
- Reset mid-stream with 2 beats in flight -> out_valid=0, pixel_out=0 after reset; no stale beat emerges; next accepted beat emitted correctly.
- DEQUANTIZE_ROUND_EN, SHIFT=8, ZERO_POINT=0, lane 8'h01 -> 32'h00000180; lane 8'hFF -> 32'hFFFFFF80; SHIFT=0 lane 8'h05 -> 32'd5.

Source files
------------

// File: rtl/dequantize.sv
// dequantize: streaming int8 -> int32 expansion with zero-point removal and left shift.
// Two registered stages (s1: zero-point removed, s2: shifted output) with valid/ready
// on both sides, full throughput and backpressure.
// Optional build macro: DEQUANTIZE_ROUND_EN adds the truncation-bin midpoint in stage 2.
module dequantize #(
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned SIZE       = 1,
  parameter int          ZERO_POINT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [8*SIZE-1:0]    pixel_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [32*SIZE-1:0]   pixel_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned IN_W  = 8;
  localparam int unsigned D_W   = 9;
  localparam int unsigned OUT_W = 32;

  // Zero-point as a 9-bit two's complement constant (sign-extended from 8 bits).
  localparam logic [D_W-1:0] ZP_D = D_W'(ZERO_POINT);

`ifdef DEQUANTIZE_ROUND_EN
  // Midpoint of the truncation bin; zero when no shift is applied.
  localparam logic [OUT_W-1:0] ROUND_OFS =
    (SHIFT > 0) ? (OUT_W'(1) << (SHIFT - 1)) : '0;
`endif

  logic [SIZE-1:0][D_W-1:0]   d_c;
  logic [SIZE-1:0][D_W-1:0]   s1_d;
  logic [SIZE-1:0][OUT_W-1:0] q_c;
  logic                       s1_valid;
  logic                       s2_load_c;
  logic                       in_xfer_c;

  // Handshake: s1 advances when s2 is empty or draining; input accepted when s1 frees up.
  always_comb begin
    s2_load_c = s1_valid && (!out_valid || out_ready);
    in_ready  = !reset && (!s1_valid || s2_load_c);
    in_xfer_c = in_valid && in_ready;
  end

  // Stage 1 datapath: sign-extend each lane to 9 bits and remove the zero-point.
  always_comb begin
    d_c = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      logic [IN_W-1:0] lane;
      lane   = pixel_in[IN_W*i +: IN_W];
      d_c[i] = {lane[IN_W-1], lane} - ZP_D;
    end
  end

  // Stage 2 datapath: sign-extend to 32 bits and shift into the accumulator domain.
  always_comb begin
    q_c = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      q_c[i] = {{(OUT_W-D_W){s1_d[i][D_W-1]}}, s1_d[i]} << SHIFT;
`ifdef DEQUANTIZE_ROUND_EN
      q_c[i] = q_c[i] + ROUND_OFS;
`endif
    end
  end

  // Stage 1 register: loads only on an input transfer, empties when it moves on alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
    end else if (in_xfer_c) begin
      s1_valid <= 1'b1;
      s1_d     <= d_c;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: loads from s1 when free, otherwise clears on output transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else if (s2_load_c) begin
      out_valid <= 1'b1;
      pixel_out <= q_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dequantize.sv
// tb_dequantize: randomized, self-checking bench for dequantize (SIZE=2).
// Several instances with different SHIFT/ZERO_POINT share one input stream.
module tb_dequantize;

  logic        clock;
  logic        reset;
  logic [15:0] pixel_in;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready,  in_ready_zlo, in_ready_zhi, in_ready_s8, in_ready_s23;
  logic        out_valid, out_valid_zlo, out_valid_zhi, out_valid_s8, out_valid_s23;
  logic [63:0] pixel_out, pixel_out_zlo, pixel_out_zhi, pixel_out_s8, pixel_out_s23;

  int n_vec = 0;
  int n_err = 0;

  dequantize #(.SHIFT(4), .SIZE(2), .ZERO_POINT(0)) u_main (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready), .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready));
  dequantize #(.SHIFT(0), .SIZE(2), .ZERO_POINT(-128)) u_zlo (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready_zlo), .pixel_out(pixel_out_zlo), .out_valid(out_valid_zlo), .out_ready(out_ready));
  dequantize #(.SHIFT(0), .SIZE(2), .ZERO_POINT(127)) u_zhi (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready_zhi), .pixel_out(pixel_out_zhi), .out_valid(out_valid_zhi), .out_ready(out_ready));
  dequantize #(.SHIFT(8), .SIZE(2), .ZERO_POINT(0)) u_s8 (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready_s8), .pixel_out(pixel_out_s8), .out_valid(out_valid_s8), .out_ready(out_ready));
  dequantize #(.SHIFT(23), .SIZE(2), .ZERO_POINT(-128)) u_s23 (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready_s23), .pixel_out(pixel_out_s23), .out_valid(out_valid_s23), .out_ready(out_ready));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: value = (pixel - zero_point) * 2^shift (+ half step when rounding).
  function automatic logic [31:0] ref_lane(input logic [7:0] p, input int zp, input int sh);
    int d;
    int q;
    d = int'($signed(p)) - zp;
    q = d * (1 << sh);
`ifdef DEQUANTIZE_ROUND_EN
    if (sh > 0) q = q + (1 << (sh - 1));
`endif
    return 32'(q);
  endfunction

  function automatic logic [63:0] ref_beat(input logic [15:0] px, input int zp, input int sh);
    return {ref_lane(px[15:8], zp, sh), ref_lane(px[7:0], zp, sh)};
  endfunction

  // Apply one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic rst, input logic v, input logic [15:0] px, input logic ordy);
    @(posedge clock);
    #1;
    reset     = rst;
    in_valid  = v;
    pixel_in  = px;
    out_ready = ordy;
    @(negedge clock);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 16'h1234, 1'b1);
    drive(1'b1, 1'b1, 16'h5678, 1'b1);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_vec++;
    if (pixel_out !== 64'h0) begin
      n_err++; $display("FAIL reset_pixel_out got=%h exp=0", pixel_out);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_no_beat got=%b exp=0", out_valid);
    end
  endtask

  // Isolated beats: latency of two cycles, every instance checked against the model.
  task automatic test_single;
    logic [15:0] beats [2];
    beats[0] = 16'h807F;
    beats[1] = 16'hFF01;
    for (int b = 0; b < 2; b++) begin
      drive(1'b0, 1'b1, beats[b], 1'b1);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL single_in_ready got=%b exp=1", in_ready);
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL single_early got=%b exp=0", out_valid);
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL single_valid got=%b exp=1", out_valid);
      end
      n_vec++;
      if (pixel_out !== ref_beat(beats[b], 0, 4)) begin
        n_err++; $display("FAIL single_main got=%h exp=%h", pixel_out, ref_beat(beats[b], 0, 4));
      end
      n_vec++;
      if (pixel_out_zlo !== ref_beat(beats[b], -128, 0)) begin
        n_err++; $display("FAIL single_zp_lo got=%h exp=%h", pixel_out_zlo, ref_beat(beats[b], -128, 0));
      end
      n_vec++;
      if (pixel_out_zhi !== ref_beat(beats[b], 127, 0)) begin
        n_err++; $display("FAIL single_zp_hi got=%h exp=%h", pixel_out_zhi, ref_beat(beats[b], 127, 0));
      end
      n_vec++;
      if (pixel_out_s8 !== ref_beat(beats[b], 0, 8)) begin
        n_err++; $display("FAIL single_shift8 got=%h exp=%h", pixel_out_s8, ref_beat(beats[b], 0, 8));
      end
      n_vec++;
      if (pixel_out_s23 !== ref_beat(beats[b], -128, 23)) begin
        n_err++; $display("FAIL single_shift23 got=%h exp=%h", pixel_out_s23, ref_beat(beats[b], -128, 23));
      end
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL single_after got=%b exp=0", out_valid);
      end
    end
  endtask

  // Two beats fill the pipe under backpressure; release drains them in order with no gap.
  task automatic test_backpressure;
    logic [15:0] b [3];
    logic        exp_rdy [5];
    for (int i = 0; i < 3; i++) b[i] = 16'($urandom);
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, b[(c < 2) ? c : 2], (c == 4));
      n_vec++;
      if (in_ready !== exp_rdy[c]) begin
        n_err++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy[c]);
      end
      if (c >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || pixel_out !== ref_beat(b[0], 0, 4)) begin
          n_err++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, out_valid, pixel_out, ref_beat(b[0], 0, 4));
        end
      end
    end
    for (int c = 1; c < 4; c++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      if (c < 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || pixel_out !== ref_beat(b[c], 0, 4)) begin
          n_err++; $display("FAIL bp_drain beat=%0d got=%b/%h exp=1/%h", c, out_valid, pixel_out, ref_beat(b[c], 0, 4));
        end
      end else begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL bp_dup got=%b exp=0", out_valid);
        end
      end
    end
  endtask

  // 100 random beats with random in_valid/out_ready, scoreboarded against the model.
  task automatic test_stream;
    logic [15:0] q [$];
    logic [15:0] px;
    logic [63:0] held;
    logic        held_v;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0; recv = 0; cyc = 0; held_v = 1'b0; held = '0;
    while (recv < 100 && cyc < 3000) begin
      drive(1'b0, (sent < 100) && ($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 1) == 1));
      cyc++;
      if (held_v) begin
        n_vec++;
        if (out_valid !== 1'b1 || pixel_out !== held) begin
          n_err++; $display("FAIL stream_stall got=%b/%h exp=1/%h", out_valid, pixel_out, held);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(pixel_in);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stream_extra got=%h exp=none", pixel_out);
        end else begin
          px = q.pop_front();
          recv++;
          if (pixel_out !== ref_beat(px, 0, 4) || pixel_out_zhi !== ref_beat(px, 127, 0) ||
              pixel_out_s23 !== ref_beat(px, -128, 23)) begin
            n_err++;
            $display("FAIL stream_data beat=%0d got=%h/%h/%h exp=%h/%h/%h", recv, pixel_out, pixel_out_zhi,
                     pixel_out_s23, ref_beat(px, 0, 4), ref_beat(px, 127, 0), ref_beat(px, -128, 23));
          end
        end
      end
      held_v = out_valid && !out_ready;
      held   = pixel_out;
    end
    n_vec++;
    if (recv != 100) begin
      n_err++; $display("FAIL stream_timeout got=%0d exp=100", recv);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_leftover got=%b exp=0", out_valid);
    end
  endtask

  // Full throughput: 16 beats with both handshakes high complete in 18 cycles.
  task automatic test_back_to_back;
    logic [15:0] q [$];
    logic [15:0] px;
    int          last;
    int          recv;
    last = -1; recv = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, (c < 16), 16'($urandom), 1'b1);
      if (c < 16) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready);
        end
      end
      if (in_valid && in_ready) q.push_back(pixel_in);
      if (out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra got=%h exp=none", pixel_out);
        end else begin
          px = q.pop_front();
          recv++;
          last = c;
          if (pixel_out !== ref_beat(px, 0, 4)) begin
            n_err++; $display("FAIL b2b_data got=%h exp=%h", pixel_out, ref_beat(px, 0, 4));
          end
        end
      end
    end
    n_vec++;
    if (recv != 16 || last + 1 != 18) begin
      n_err++; $display("FAIL b2b_cycles got=%0d beats/%0d cycles exp=16/18", recv, last + 1);
    end
  endtask

  // Reset with two beats in flight discards them; the next beat flows normally.
  task automatic test_mid_reset;
    logic [15:0] b;
    drive(1'b0, 1'b1, 16'($urandom), 1'b0);
    drive(1'b0, 1'b1, 16'($urandom), 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready);
    end
    drive(1'b1, 1'b1, 16'hAAAA, 1'b1);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_ready got=%b exp=0", in_ready);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || pixel_out !== 64'h0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_after got=%b/%h/%b exp=0/0/1", out_valid, pixel_out, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_stale c=%0d got=%b exp=0", c, out_valid);
      end
    end
    b = 16'($urandom);
    drive(1'b0, 1'b1, b, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || pixel_out !== ref_beat(b, 0, 4)) begin
      n_err++; $display("FAIL mid_next got=%b/%h exp=1/%h", out_valid, pixel_out, ref_beat(b, 0, 4));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    pixel_in  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
